dualmem_stream_writer: RTL and testbench
========================================

// Module: dualmem_stream_writer
// PURPOSE
//  Frame writer on the 16-bit port A side of the 16/64-bit widening dual-port buffer.
//  Accepts one frame as a 16-bit valid/ready stream and writes it as halfwords from address 0.
//  Then presents the frame length to the 64-bit side and holds until that side acknowledges.
//  Oversized frames are dropped, not truncated.
// PARAMETERS
//  ADDR_W   11   halfword address width; buffer depth DEPTH = 2**ADDR_W halfwords
//  DATA_W   16   stream/port-A data width (fixed 16; two byte lanes)
// PORTS
//  clk           in   1         single clock; drives the buffer's port A clock
//  rstn          in   1         asynchronous active-low reset
//  s_data        in   16        stream halfword; byte 0 = [7:0], byte 1 = [15:8]
//  s_valid       in   1         beat valid
//  s_last        in   1         final beat of frame
//  s_last_odd    in   1         qualifies s_last: only [7:0] is valid
//  s_ready       out  1         beat accepted when s_valid & s_ready
//  mem_en        out  1         port A enable
//  mem_we        out  2         port A byte write enables
//  mem_addr      out  ADDR_W    port A halfword address
//  mem_wdata     out  16        port A write data
//  frame_valid   out  1         complete frame resident in buffer
//  frame_len     out  ADDR_W+2  frame length in bytes (1..2*DEPTH)
//  frame_ack     in   1         64-bit side consumed frame; buffer may be reused
// BEHAVIOUR
//  Reset: all outputs 0 and state IDLE; wr_ptr=0; any partial frame is discarded.
//  - s_ready rises on the first clk edge after rstn deasserts.
//  All outputs are registered.
//  States:
//  - IDLE: s_ready=1. First accepted beat -> FILL, or -> HOLD if s_last.
//  - FILL: s_ready=1; each accepted beat writes at wr_ptr, then wr_ptr++. s_last -> HOLD.
//  - HOLD: s_ready=0; frame_valid=1; frame_ack -> IDLE with wr_ptr=0 and frame_valid=0 next cycle.
//  - DROP: s_ready=1; no writes. Accepted s_last -> IDLE; frame_valid stays 0.
//  Write timing: a beat accepted in cycle N is presented in cycle N+1.
//  - mem_en=1; mem_addr=wr_ptr; mem_wdata=s_data.
//  - mem_we=2'b11, or 2'b01 when s_last & s_last_odd.
//  - In all other cycles mem_en=0 and mem_we=0.
//  Commit: last beat accepted in N -> last write in N+1 -> frame_valid=1 from N+2.
//  - s_ready=0 from N+1.
//  - frame_len = 2*beats - (s_last_odd ? 1 : 0); stable while frame_valid=1.
//  Overflow: a beat accepted while wr_ptr==DEPTH (buffer already full) is not written.
//  - That beat moves the state to DROP; if it also carries s_last, go straight to IDLE.
//  - A frame of exactly DEPTH beats is legal: frame_len = 2*DEPTH, or 2*DEPTH-1 if odd.
//  wr_ptr is ADDR_W+1 bits wide; it never wraps.
//  frame_ack outside HOLD is ignored. frame_ack in the same cycle frame_valid rises is honoured.
//  s_last_odd without s_last is ignored; the beat is written as a full halfword.
//  Single-beat frame: IDLE -> HOLD directly; frame_len = 2, or 1 if odd.
// CONFIGURATION
//  DUALMEM_WRITER_DROPCNT_EN defined:
//  - Adds output drop_cnt [15:0]: count of dropped frames, saturating at 16'hFFFF.
//  - Increments once per entry into DROP (or per direct overflow-to-IDLE); reset 0.
//  Undefined: port absent; drop behaviour otherwise identical.
// TESTING
//  1. Reset, then 4 beats 16'h1111..16'h4444, last not odd.
//     -> writes to addr 0..3 with we=2'b11; frame_valid two cycles after last beat; frame_len=8.
//  2. 3-beat frame, last odd, data 16'hABCD.
//     -> addr 2 written with we=2'b01; frame_len=5; s_ready=0 until frame_ack.
//  3. frame_ack in HOLD.
//     -> next cycle frame_valid=0, s_ready=1; next frame writes from addr 0.
//  4. 2049-beat frame (ADDR_W=11).
//     -> addrs 0..2047 written; no write for beat 2049; frame dropped, frame_valid=0.
//     -> drop_cnt=1 when DUALMEM_WRITER_DROPCNT_EN defined.
//  5. 2048-beat frame with last odd -> frame_len=4095; last write we=2'b01 at addr 2047.
//  6. rstn low mid-FILL after 10 beats -> outputs 0 immediately.
//     -> after release, a 1-beat frame gives frame_len=2 at addr 0.

Source files
------------

// File: rtl/dualmem_stream_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dualmem_stream_writer                                        |
// | Description : Writes one 16-bit valid/ready stream frame as halfwords into |
// |               port A of the 16/64-bit widening buffer from address 0. It   |
// |               then offers the byte length to the 64-bit side and holds     |
// |               until that side acknowledges. Frames longer than the buffer  |
// |               are dropped whole.                                           |
// |               Optional: DUALMEM_WRITER_DROPCNT_EN adds a saturating        |
// |               drop_cnt output that counts dropped frames.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module dualmem_stream_writer #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  input  logic              s_last_odd,
  output logic              s_ready,
  output logic              mem_en,
  output logic [1:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              frame_valid,
  output logic [ADDR_W+1:0] frame_len,
  input  logic              frame_ack
`ifdef DUALMEM_WRITER_DROPCNT_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);

  // wr_ptr equal to this value means every halfword of the buffer is used
  localparam logic [ADDR_W:0] FULL_PTR = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] PTR_ONE  = (ADDR_W+1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic                s_ready_q, s_ready_d;
  logic                mem_en_q, mem_en_d;
  logic [1:0]          mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                frame_valid_q, frame_valid_d;
  logic [ADDR_W+1:0]   frame_len_q, frame_len_d;

  logic accept;
  logic full;
  logic odd_end;

  assign accept  = s_valid & s_ready_q;
  assign full    = (wr_ptr_q == FULL_PTR);
  // s_last_odd only matters on the final beat
  assign odd_end = s_last & s_last_odd;

  // Next-state, write-port and frame-length decode; outputs are registered from these
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 2'b00;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    frame_len_d = frame_len_q;
    case (state_q)
      IDLE, FILL: begin
        if (accept) begin
          if (full) begin
            // Oversized frame: discard the rest; a closing beat goes straight back to IDLE
            if (s_last) begin
              state_d  = IDLE;
              wr_ptr_d = '0;
            end else begin
              state_d = DROP;
            end
          end else begin
            mem_en_d    = 1'b1;
            mem_we_d    = odd_end ? 2'b01 : 2'b11;
            mem_addr_d  = wr_ptr_q[ADDR_W-1:0];
            mem_wdata_d = s_data;
            wr_ptr_d    = wr_ptr_q + PTR_ONE;
            if (s_last) begin
              state_d     = HOLD;
              frame_len_d = {wr_ptr_d, 1'b0} - {{(ADDR_W+1){1'b0}}, odd_end};
            end else begin
              state_d = FILL;
            end
          end
        end
      end
      HOLD: begin
        // Ack counts once the frame has been offered (frame_valid visible)
        if (frame_valid_q && frame_ack) begin
          state_d     = IDLE;
          wr_ptr_d    = '0;
          frame_len_d = '0;
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_d  = IDLE;
          wr_ptr_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        wr_ptr_d = '0;
      end
    endcase
    s_ready_d     = (state_d != HOLD);
    // One cycle after entering HOLD, so the last write lands before the frame is offered
    frame_valid_d = (state_q == HOLD) && (state_d == HOLD);
  end

  // State and registered outputs; reset discards any partial frame
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      wr_ptr_q      <= '0;
      s_ready_q     <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 2'b00;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_len_q   <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      s_ready_q     <= s_ready_d;
      mem_en_q      <= mem_en_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      frame_valid_q <= frame_valid_d;
      frame_len_q   <= frame_len_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign frame_valid = frame_valid_q;
  assign frame_len   = frame_len_q;

`ifdef DUALMEM_WRITER_DROPCNT_EN
  logic        drop_event;
  logic [15:0] drop_cnt_q;

  // Every drop starts with a beat accepted into a full buffer
  assign drop_event = accept && full && ((state_q == IDLE) || (state_q == FILL));

  // Saturating count of dropped frames
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      drop_cnt_q <= 16'd0;
    end else if (drop_event && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dualmem_stream_writer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dualmem_stream_writer                                     |
// | Description : Randomised self-checking bench for dualmem_stream_writer.    |
// |               Build with DUALMEM_WRITER_DROPCNT_EN to cover drop_cnt.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_dualmem_stream_writer;

  localparam int ADDR_W = 11;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rstn = 1'b1;
  logic [15:0]       s_data = '0;
  logic              s_valid = 1'b0;
  logic              s_last = 1'b0;
  logic              s_last_odd = 1'b0;
  logic              s_ready;
  logic              mem_en;
  logic [1:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              frame_valid;
  logic [ADDR_W+1:0] frame_len;
  logic              frame_ack = 1'b0;
`ifdef DUALMEM_WRITER_DROPCNT_EN
  logic [15:0]       drop_cnt;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_drops = 0;

  typedef struct {
    int          a;
    logic [1:0]  we;
    logic [15:0] d;
    int          c;
  } wr_t;

  wr_t wq[$];
  int  aq[$];

  dualmem_stream_writer #(.ADDR_W(ADDR_W), .DATA_W(16)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_last      (s_last),
    .s_last_odd  (s_last_odd),
    .s_ready     (s_ready),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_ack   (frame_ack)
`ifdef DUALMEM_WRITER_DROPCNT_EN
    ,
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe accepted beats and port-A writes mid-cycle
  always @(negedge clk) begin
    if (rstn && s_valid && s_ready) aq.push_back(cyc);
    if (mem_en) wq.push_back('{int'(mem_addr), mem_we, mem_wdata, cyc});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    s_valid = 1'b0; s_last = 1'b0; s_last_odd = 1'b0; s_data = '0; frame_ack = 1'b0;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({s_ready, mem_en, mem_we, mem_addr, mem_wdata, frame_valid, frame_len} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h, want 0",
               {s_ready, mem_en, mem_we, mem_addr, mem_wdata, frame_valid, frame_len});
    end
`ifdef DUALMEM_WRITER_DROPCNT_EN
    tests++;
    if (drop_cnt !== 16'd0) begin
      fails++;
      $display("FAIL reset_drop_cnt: got %0d, want 0", drop_cnt);
    end
`endif
    @(negedge clk) rstn = 1'b1;
    #1;
    tests++;
    if (s_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_before_edge: got %b, want 0", s_ready);
    end
    @(posedge clk);
    #1;
    tests++;
    if (s_ready !== 1'b1 || frame_valid !== 1'b0) begin
      fails++;
      $display("FAIL ready_after_edge: got ready=%b valid=%b, want ready=1 valid=0", s_ready, frame_valid);
    end
  endtask

  // mode: 0 random data, 1 ramp 16'h1111*(k+1), 2 constant 16'hABCD
  task automatic test_frame(input int n, input bit odd, input int mode, input int ack_dly, input string tag);
    logic [15:0] dat[$];
    int          i, stall, nw, exp_len;
    bit          commit, aborted;
    logic [1:0]  exp_we;
    for (int k = 0; k < n; k++) begin
      if (mode == 1)      dat.push_back(16'(16'h1111 * (k + 1)));
      else if (mode == 2) dat.push_back(16'hABCD);
      else                dat.push_back(16'($urandom));
    end
    commit  = (n <= DEPTH);
    exp_len = 2 * n - (odd ? 1 : 0);
    nw      = commit ? n : DEPTH;
    @(posedge clk);
    #1;
    wq.delete();
    aq.delete();
    i = 0; stall = 0; aborted = 1'b0;
    while (i < n) begin
      // Acks outside HOLD must be ignored
      frame_ack = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        s_valid = 1'b0; s_last = 1'b0; s_data = 16'($urandom);
        s_last_odd = ($urandom_range(0, 1) == 1);
        @(posedge clk);
        #1;
        continue;
      end
      s_valid = 1'b1;
      s_data  = dat[i];
      s_last  = (i == n - 1);
      // s_last_odd on a non-final beat must not shorten the write
      s_last_odd = (i == n - 1) ? odd : ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (s_ready) begin
        @(posedge clk);
        #1;
        i++;
        stall = 0;
      end else begin
        stall++;
        @(posedge clk);
        #1;
        if (stall > 50) begin
          tests++; fails++;
          $display("FAIL %s ready_timeout: beat %0d not accepted after 50 cycles, want accepted", tag, i);
          aborted = 1'b1;
          break;
        end
      end
    end
    s_valid = 1'b0; s_last = 1'b0; s_last_odd = 1'b0; frame_ack = 1'b0;
    if (aborted) return;

    // Cycle right after the last beat was accepted
    @(negedge clk);
    tests++;
    if (commit ? (s_ready !== 1'b0 || frame_valid !== 1'b0) : (s_ready !== 1'b1 || frame_valid !== 1'b0)) begin
      fails++;
      $display("FAIL %s after_last: got ready=%b valid=%b, want ready=%b valid=0",
               tag, s_ready, frame_valid, !commit);
    end
    @(posedge clk);
    #1;
    if (commit) begin
      if (ack_dly == 0) frame_ack = 1'b1;
      @(negedge clk);
      tests++;
      if (frame_valid !== 1'b1 || int'(frame_len) != exp_len || s_ready !== 1'b0) begin
        fails++;
        $display("FAIL %s frame_offer: got valid=%b len=%0d ready=%b, want valid=1 len=%0d ready=0",
                 tag, frame_valid, frame_len, s_ready, exp_len);
      end
      for (int d = 1; d <= ack_dly; d++) begin
        @(posedge clk);
        #1;
        if (d == ack_dly) frame_ack = 1'b1;
        @(negedge clk);
        tests++;
        if (frame_valid !== 1'b1 || int'(frame_len) != exp_len || s_ready !== 1'b0) begin
          fails++;
          $display("FAIL %s frame_hold: got valid=%b len=%0d ready=%b, want valid=1 len=%0d ready=0",
                   tag, frame_valid, frame_len, s_ready, exp_len);
        end
      end
      @(posedge clk);
      #1;
      frame_ack = 1'b0;
      @(negedge clk);
      tests++;
      if (frame_valid !== 1'b0 || s_ready !== 1'b1) begin
        fails++;
        $display("FAIL %s after_ack: got valid=%b ready=%b, want valid=0 ready=1", tag, frame_valid, s_ready);
      end
    end else begin
      exp_drops++;
      repeat (3) begin
        @(negedge clk);
        tests++;
        if (frame_valid !== 1'b0 || s_ready !== 1'b1 || mem_en !== 1'b0) begin
          fails++;
          $display("FAIL %s dropped_idle: got valid=%b ready=%b en=%b, want valid=0 ready=1 en=0",
                   tag, frame_valid, s_ready, mem_en);
        end
      end
`ifdef DUALMEM_WRITER_DROPCNT_EN
      tests++;
      if (drop_cnt !== 16'(exp_drops)) begin
        fails++;
        $display("FAIL %s drop_cnt: got %0d, want %0d", tag, drop_cnt, exp_drops);
      end
`endif
    end

    tests++;
    if (aq.size() != n) begin
      fails++;
      $display("FAIL %s accept_count: got %0d, want %0d", tag, aq.size(), n);
    end
    tests++;
    if (wq.size() != nw) begin
      fails++;
      $display("FAIL %s write_count: got %0d, want %0d", tag, wq.size(), nw);
    end
    for (int k = 0; k < nw && k < wq.size(); k++) begin
      exp_we = (k == n - 1 && odd) ? 2'b01 : 2'b11;
      tests++;
      if (wq[k].a != k || wq[k].we !== exp_we || wq[k].d !== dat[k] ||
          (k < aq.size() && wq[k].c != aq[k] + 1)) begin
        fails++;
        $display("FAIL %s write[%0d]: got addr=%0d we=%b data=%h cyc=%0d, want addr=%0d we=%b data=%h cyc=%0d",
                 tag, k, wq[k].a, wq[k].we, wq[k].d, wq[k].c, k, exp_we, dat[k],
                 (k < aq.size()) ? aq[k] + 1 : -1);
      end
    end
  endtask

  task automatic test_reset_mid_fill();
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1; s_data = 16'($urandom); s_last = 1'b0; s_last_odd = 1'b0;
      @(negedge clk);
      tests++;
      if (s_ready !== 1'b1) begin
        fails++;
        $display("FAIL mid_fill_ready[%0d]: got %b, want 1", k, s_ready);
      end
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    tests++;
    if (mem_en !== 1'b1 || int'(mem_addr) != 9) begin
      fails++;
      $display("FAIL mid_fill_write: got en=%b addr=%0d, want en=1 addr=9", mem_en, mem_addr);
    end
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({s_ready, mem_en, mem_we, mem_addr, mem_wdata, frame_valid, frame_len} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %h, want 0",
               {s_ready, mem_en, mem_we, mem_addr, mem_wdata, frame_valid, frame_len});
    end
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_frame(4, 1'b0, 1, 2, "ramp4");
    test_frame(3, 1'b1, 2, 3, "odd3");
    test_frame(1, 1'b1, 0, 0, "single_odd");
    test_frame(1, 1'b0, 0, 1, "single");
    for (int r = 0; r < 6; r++) begin
      test_frame(int'($urandom_range(2, 40)), ($urandom_range(0, 1) == 1), 0,
                 int'($urandom_range(0, 4)), "random");
    end
    test_frame(DEPTH + 1, 1'b0, 0, 1, "overflow_last");
    test_frame(DEPTH, 1'b1, 0, 1, "full_odd");
    test_frame(DEPTH, 1'b0, 0, 0, "full_even");
    test_frame(DEPTH + 4, 1'b1, 0, 1, "overflow_drop");
    test_frame(5, 1'b0, 0, 2, "after_drop");
    test_reset_mid_fill();
    test_frame(1, 1'b0, 0, 1, "post_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
